sad_tree_min_select: RTL and testbench
======================================

// Module: sad_tree_min_select
// PURPOSE
//  Consumes the 1024 per-pixel absolute differences of the 32x32 PE array, one candidate per valid cycle.
//  A 3-stage pipelined adder tree produces 16 8x8, 4 16x16 and 1 32x32 SAD for that candidate.
//  A raster candidate counter and min-tracker return the best 32x32 motion vector over one search window.
// PARAMETERS
//  PIXEL        8   bits per absolute difference
//  SR           16  search range; candidates mv_x,mv_y in [-SR, SR-1]; (2*SR)^2 candidates per search
//  MVW          6   signed MV width, two's complement; must hold -SR..SR-1
//  LAMBDA_SHIFT 2   MV cost weight (ME_MV_COST_EN only)
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  abs_outs     in   8192   32x32 ADs; pixel (r,c) at [(r*32+c)*8 +: 8]
//  abs_valid    in   1      abs_outs holds one candidate this cycle
//  search_start in   1      pulse: begin a new search window; restarts counter and min
//  sad_8x8      out  16*14  block b=(r/8)*4+c/8 at [b*14 +: 14]
//  sad_16x16    out  4*16   block q=(r/16)*2+c/16 at [q*16 +: 16]
//  sad_32x32    out  18     full-block SAD
//  sad_valid    out  1      all sad_* outputs belong to one candidate
//  best_sad     out  18     raw 32x32 SAD of winning candidate
//  best_mv_x    out  MVW    signed winning MV x
//  best_mv_y    out  MVW    signed winning MV y
//  search_done  out  1      one-cycle pulse; best_* valid and held until next search_start
// BEHAVIOUR
//  - Reset: every output 0, sad_valid=0, search_done=0, FSM IDLE, pipeline valid bits cleared.
//  - Tree: S1 registers 8x8 sums; S2 registers 16x16 sums plus the delayed 8x8 sums; S3 registers the 32x32 sum
//    plus the delayed 8x8 and 16x16 sums. Latency 3: abs_valid at cycle N -> sad_valid at N+3, fully pipelined,
//    back-to-back valids accepted with no bubbles. sad_* hold their last value while sad_valid=0.
//  - Widths: unsigned, sized to never overflow: 14/16/18 bits (max 16320/65280/261120).
//  - FSM IDLE -> SCAN on search_start; SCAN -> DONE when the sad_valid for candidate (2*SR)^2-1 is consumed;
//    DONE -> IDLE after one cycle with search_done=1. search_start in any state -> SCAN, counter=0,
//    min=all ones; the start cycle counts as cycle 0, and a sad_valid in that same cycle is candidate 0.
//  - Counter k advances only on sad_valid while in SCAN; mv_x=(k mod 2SR)-SR, mv_y=(k div 2SR)-SR.
//    sad_valid in IDLE/DONE: sad_* update, counter and min untouched.
//  - Compare: update best on cost < min, strictly; ties keep the earliest candidate in raster order.
//  - best_* register the winner at the DONE transition and stay stable through IDLE.
//    They change only at the next DONE or on reset.
//  - Upstream contract: ADs reaching the tree in flight before search_start belong to the previous window.
//    They are counted if they arrive at sad_valid after the start; the caller must drain or not overlap.
// CONFIGURATION
//  ME_MV_COST_EN defined: cost = sad_32x32 + ((|mv_x|+|mv_y|) << LAMBDA_SHIFT), 20 bits wide.
//    best_sad still reports the raw SAD of the winner.
//  ME_MV_COST_EN undefined: cost = sad_32x32; no MV-cost logic synthesised.
// TESTING
//  1 all ADs 0x01, single abs_valid -> 3 cycles later sad_valid=1: each 8x8=64, 16x16=256, 32x32=1024.
//  2 all ADs 0xFF -> 8x8=16320, 16x16=65280, 32x32=261120, no wrap.
//    Then 0x00 on the next cycle -> 0s exactly one cycle later.
//  3 SR=2, 16 candidates, SAD=1000-k except k=9 set to 5 -> search_done one cycle after 16th sad_valid;
//    best_sad=5, mv=(-1,0).
//  4 SR=2, all 16 candidates SAD=500 -> best_sad=500, mv=(-2,-2) (first wins tie).
//  5 search_start re-pulsed after candidate 5 of 16 -> 16 further candidates needed before done;
//    earlier smaller SAD discarded.
//  6 rst_n low for 1 cycle with 2 valids in pipeline -> all outputs 0.
//    No sad_valid or search_done follows; FSM IDLE.
//  7 ME_MV_COST_EN, LAMBDA_SHIFT=2, SR=2, all SAD=100 except mv (1,1) SAD=95 -> mv (0,0) wins (cost 100 vs 103).

Source files
------------

// File: rtl/sad_tree_min_select.sv
// 32x32 SAD adder tree (8x8/16x16/32x32, 3-stage pipeline) with raster motion-vector min search.
// Optional MV-cost weighting is enabled by defining ME_MV_COST_EN.
module sad_tree_min_select #(
   parameter int unsigned PIXEL = 8,
   parameter int unsigned SR    = 16,
   parameter int unsigned MVW   = 6
`ifdef ME_MV_COST_EN
   ,
   parameter int unsigned LAMBDA_SHIFT = 2
`endif
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [32*32*PIXEL-1:0]     abs_outs,
   input  logic                       abs_valid,
   input  logic                       search_start,
   output logic [16*(PIXEL+6)-1:0]    sad_8x8,
   output logic [4*(PIXEL+8)-1:0]     sad_16x16,
   output logic [PIXEL+9:0]           sad_32x32,
   output logic                       sad_valid,
   output logic [PIXEL+9:0]           best_sad,
   output logic signed [MVW-1:0]      best_mv_x,
   output logic signed [MVW-1:0]      best_mv_y,
   output logic                       search_done
);

   localparam int unsigned W8  = PIXEL + 6;
   localparam int unsigned W16 = PIXEL + 8;
   localparam int unsigned W32 = PIXEL + 10;
   localparam int unsigned XW  = $clog2(2 * SR);
   localparam logic [XW-1:0] MAXC = XW'(2 * SR - 1);
`ifdef ME_MV_COST_EN
   localparam int unsigned COSTW = PIXEL + 12;
`else
   localparam int unsigned COSTW = W32;
`endif

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   logic [15:0][W8-1:0]  sum8, s1_8, s2_8, s3_8;
   logic [3:0][W16-1:0]  sum16, s2_16, s3_16;
   logic [W32-1:0]       sum32, s3_32;
   logic                 v1, v2, v3;

   always_comb begin
      for (int unsigned b = 0; b < 16; b++) begin
         sum8[b] = '0;
         for (int unsigned r = 0; r < 8; r++) begin
            for (int unsigned c = 0; c < 8; c++) begin
               sum8[b] = sum8[b] + W8'(abs_outs[(((b / 4) * 8 + r) * 32 + (b % 4) * 8 + c) * PIXEL +: PIXEL]);
            end
         end
      end
   end

   always_comb begin
      for (int unsigned q = 0; q < 4; q++) begin
         sum16[q] = W16'(s1_8[(q / 2) * 8 + (q % 2) * 2])
                  + W16'(s1_8[(q / 2) * 8 + (q % 2) * 2 + 1])
                  + W16'(s1_8[(q / 2) * 8 + (q % 2) * 2 + 4])
                  + W16'(s1_8[(q / 2) * 8 + (q % 2) * 2 + 5]);
      end
      sum32 = W32'(s2_16[0]) + W32'(s2_16[1]) + W32'(s2_16[2]) + W32'(s2_16[3]);
   end

   // Stage registers load only with their valid so outputs hold between candidates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
         s1_8 <= '0; s2_8 <= '0; s3_8 <= '0;
         s2_16 <= '0; s3_16 <= '0; s3_32 <= '0;
      end else begin
         v1 <= abs_valid;
         v2 <= v1;
         v3 <= v2;
         if (abs_valid) s1_8 <= sum8;
         if (v1) begin
            s2_8  <= s1_8;
            s2_16 <= sum16;
         end
         if (v2) begin
            s3_8  <= s2_8;
            s3_16 <= s2_16;
            s3_32 <= sum32;
         end
      end
   end

   assign sad_8x8   = s3_8;
   assign sad_16x16 = s3_16;
   assign sad_32x32 = s3_32;
   assign sad_valid = v3;

   state_t                 state, state_nx;
   logic [XW-1:0]          cnt_x, cnt_y, k_x, k_y;
   logic [COSTW-1:0]       run_min, cur_min, cost;
   logic [W32-1:0]         run_sad, win_sad;
   logic signed [MVW-1:0]  run_mv_x, run_mv_y, win_mv_x, win_mv_y, mv_x, mv_y;
   logic                   take, upd, last;
`ifdef ME_MV_COST_EN
   logic [MVW-1:0]         abs_x, abs_y;
`endif

   // A start cycle acts as candidate 0 against an empty minimum
   always_comb begin
      k_x     = search_start ? '0 : cnt_x;
      k_y     = search_start ? '0 : cnt_y;
      cur_min = search_start ? '1 : run_min;
      mv_x    = $signed(MVW'(k_x) - MVW'(SR));
      mv_y    = $signed(MVW'(k_y) - MVW'(SR));
`ifdef ME_MV_COST_EN
      abs_x   = mv_x[MVW-1] ? MVW'(-mv_x) : MVW'(mv_x);
      abs_y   = mv_y[MVW-1] ? MVW'(-mv_y) : MVW'(mv_y);
      cost    = COSTW'(s3_32) + ((COSTW'(abs_x) + COSTW'(abs_y)) << LAMBDA_SHIFT);
`else
      cost    = s3_32;
`endif
      take     = v3 && (search_start || state == SCAN);
      upd      = take && (cost < cur_min);
      last     = take && (k_x == MAXC) && (k_y == MAXC);
      win_sad  = upd ? s3_32 : run_sad;
      win_mv_x = upd ? mv_x : run_mv_x;
      win_mv_y = upd ? mv_y : run_mv_y;
      state_nx = state;
      case (state)
         IDLE:    state_nx = IDLE;
         SCAN:    if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (search_start) state_nx = last ? DONE : SCAN;
      search_done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt_x    <= '0;
         cnt_y    <= '0;
         run_min  <= '1;
         run_sad  <= '0;
         run_mv_x <= '0;
         run_mv_y <= '0;
         best_sad <= '0;
         best_mv_x <= '0;
         best_mv_y <= '0;
      end else begin
         state <= state_nx;
         if (take) begin
            if (last) begin
               cnt_x <= '0;
               cnt_y <= '0;
            end else if (k_x == MAXC) begin
               cnt_x <= '0;
               cnt_y <= k_y + XW'(1);
            end else begin
               cnt_x <= k_x + XW'(1);
               cnt_y <= k_y;
            end
         end else if (search_start) begin
            cnt_x <= '0;
            cnt_y <= '0;
         end
         if (upd) begin
            run_min  <= cost;
            run_sad  <= s3_32;
            run_mv_x <= mv_x;
            run_mv_y <= mv_y;
         end else if (search_start) begin
            run_min <= '1;
         end
         if (last) begin
            best_sad  <= win_sad;
            best_mv_x <= win_mv_x;
            best_mv_y <= win_mv_y;
         end
      end
   end

endmodule

// File: tb/tb_sad_tree_min_select.sv
// Scoreboard bench for sad_tree_min_select (SR=2): directed AD patterns and small searches.
module tb_sad_tree_min_select;
   localparam int SR = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [8191:0] abs_outs = '0;
   logic          abs_valid = 1'b0;
   logic          search_start = 1'b0;
   logic [223:0]  sad_8x8;
   logic [63:0]   sad_16x16;
   logic [17:0]   sad_32x32;
   logic          sad_valid;
   logic [17:0]   best_sad;
   logic signed [5:0] best_mv_x, best_mv_y;
   logic          search_done;

   sad_tree_min_select #(.PIXEL(8), .SR(SR), .MVW(6)) dut (
      .clk(clk), .rst_n(rst_n), .abs_outs(abs_outs), .abs_valid(abs_valid),
      .search_start(search_start), .sad_8x8(sad_8x8), .sad_16x16(sad_16x16),
      .sad_32x32(sad_32x32), .sad_valid(sad_valid), .best_sad(best_sad),
      .best_mv_x(best_mv_x), .best_mv_y(best_mv_y), .search_done(search_done));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [223:0] s8;
      logic [63:0]  s16;
      logic [17:0]  s32;
   } sad_exp_t;
   typedef struct packed {
      logic [17:0] sad;
      logic [5:0]  x;
      logic [5:0]  y;
   } res_exp_t;

   sad_exp_t sb_q[$];
   res_exp_t res_q[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [8191:0] ads_uniform(input logic [7:0] v);
      logic [8191:0] a;
      for (int i = 0; i < 1024; i++) a[i*8 +: 8] = v;
      return a;
   endfunction

   function automatic sad_exp_t exp_uniform(input int v);
      sad_exp_t e;
      for (int b = 0; b < 16; b++) e.s8[b*14 +: 14] = 14'(64 * v);
      for (int q = 0; q < 4; q++) e.s16[q*16 +: 16] = 16'(256 * v);
      e.s32 = 18'(1024 * v);
      return e;
   endfunction

   function automatic logic [8191:0] ads_sad(input int n);
      logic [8191:0] a;
      int rem;
      int p;
      a = '0;
      rem = n;
      for (int i = 0; i < 64; i++) begin
         p = (rem > 255) ? 255 : rem;
         a[i*8 +: 8] = 8'(p);
         rem = rem - p;
      end
      return a;
   endfunction

   // All AD mass sits in the first pixels of row 0, i.e. block 0
   function automatic sad_exp_t exp_sad(input int n);
      sad_exp_t e;
      e = '0;
      e.s8[13:0]  = 14'(n);
      e.s16[15:0] = 16'(n);
      e.s32       = 18'(n);
      return e;
   endfunction

   function automatic logic [8191:0] ads_block();
      logic [8191:0] a;
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++)
            a[(r*32+c)*8 +: 8] = 8'((r/8)*4 + c/8 + 1);
      return a;
   endfunction

   function automatic sad_exp_t exp_block();
      sad_exp_t e;
      int q16 [4] = '{896, 1408, 2944, 3456};
      for (int b = 0; b < 16; b++) e.s8[b*14 +: 14] = 14'(64 * (b + 1));
      for (int q = 0; q < 4; q++) e.s16[q*16 +: 16] = 16'(q16[q]);
      e.s32 = 18'(8704);
      return e;
   endfunction

   task automatic apply(input logic [8191:0] a, input sad_exp_t e, input bit expect_out);
      abs_outs  = a;
      abs_valid = 1'b1;
      if (expect_out) sb_q.push_back(e);
      @(posedge clk); #1;
      abs_valid = 1'b0;
   endtask

   task automatic start_search();
      search_start = 1'b1;
      @(posedge clk); #1;
      search_start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string name);
      int seen;
      seen = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (search_done) begin
            seen = i;
            break;
         end
      end
      check(name, seen, 3);
      @(posedge clk); #1;
   endtask

   task automatic run16(input string name, input int s [16], input res_exp_t r);
      res_q.push_back(r);
      start_search();
      for (int k = 0; k < 16; k++) apply(ads_sad(s[k]), exp_sad(s[k]), 1'b1);
      wait_done(name);
      idle(2);
   endtask

   task automatic check_zero(input string p);
      check({p, "_valid"}, sad_valid, 0);
      check({p, "_done"}, search_done, 0);
      check({p, "_s8"}, sad_8x8, 0);
      check({p, "_s16"}, sad_16x16, 0);
      check({p, "_s32"}, sad_32x32, 0);
      check({p, "_best"}, best_sad, 0);
      check({p, "_mvx"}, {best_mv_x}, 0);
      check({p, "_mvy"}, {best_mv_y}, 0);
   endtask

   // Monitor: compares every presented output against the queued expectation
   initial begin
      sad_exp_t e;
      res_exp_t r;
      forever begin
         @(negedge clk);
         if (sad_valid) begin
            if (sb_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_sad_valid: got sad_32x32=%0d expected no output", sad_32x32);
            end else begin
               e = sb_q.pop_front();
               check("sad_8x8", sad_8x8, e.s8);
               check("sad_16x16", sad_16x16, e.s16);
               check("sad_32x32", sad_32x32, e.s32);
            end
         end
         if (search_done) begin
            if (res_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_search_done: got best_sad=%0d expected no done", best_sad);
            end else begin
               r = res_q.pop_front();
               check("best_sad", best_sad, r.sad);
               check("best_mv_x", {best_mv_x}, r.x);
               check("best_mv_y", {best_mv_y}, r.y);
            end
         end
      end
   end

   initial begin
      int s [16];
      sad_exp_t none;
      res_exp_t r;
      none = '0;

      idle(3);
      check_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // all ones: latency 3, then hold
      apply(ads_uniform(8'h01), exp_uniform(1), 1'b1);
      @(negedge clk); check("lat_c1", sad_valid, 0);
      @(negedge clk); check("lat_c2", sad_valid, 0);
      @(negedge clk); check("lat_c3", sad_valid, 1);
      @(negedge clk); check("hold_valid", sad_valid, 0);
      check("hold_s32", sad_32x32, 1024);
      @(posedge clk); #1;

      // saturating maximum followed back-to-back by zero
      apply(ads_uniform(8'hFF), exp_uniform(255), 1'b1);
      apply(ads_uniform(8'h00), exp_uniform(0), 1'b1);
      idle(5);

      // distinct value per 8x8 block exercises output indexing
      apply(ads_block(), exp_block(), 1'b1);
      idle(5);

      // minimum at k=9 -> mv (-1,0)
      for (int k = 0; k < 16; k++) s[k] = 1000 - k;
      s[9] = 5;
      r.sad = 18'd5; r.x = -6'sd1; r.y = 6'sd0;
      run16("done_lat_min", s, r);

      // all equal: earliest candidate wins
      for (int k = 0; k < 16; k++) s[k] = 500;
      r.sad = 18'd500; r.x = -6'sd2; r.y = -6'sd2;
      run16("done_lat_tie", s, r);

      // restart after 6 candidates discards the earlier small SAD
      r.sad = 18'd985; r.x = 6'sd1; r.y = 6'sd1;
      res_q.push_back(r);
      start_search();
      for (int k = 0; k < 6; k++) apply(ads_sad(k == 2 ? 3 : 800), exp_sad(k == 2 ? 3 : 800), 1'b1);
      idle(5);
      start_search();
      for (int k = 0; k < 16; k++) apply(ads_sad(1000 - k), exp_sad(1000 - k), 1'b1);
      wait_done("done_lat_restart");
      idle(2);

      // (1,1) has raw 95; with MV cost it loses to (0,0) at 100
      for (int k = 0; k < 16; k++) s[k] = 100;
      s[15] = 95;
`ifdef ME_MV_COST_EN
      r.sad = 18'd100; r.x = 6'sd0; r.y = 6'sd0;
`else
      r.sad = 18'd95; r.x = 6'sd1; r.y = 6'sd1;
`endif
      run16("done_lat_cost", s, r);

      // reset with two candidates in flight
      apply(ads_uniform(8'h01), none, 1'b0);
      apply(ads_uniform(8'h02), none, 1'b0);
      rst_n = 1'b0;
      #2;
      check_zero("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(8);

      // sad_valid in IDLE updates sad_* without completing a search
      apply(ads_uniform(8'h03), exp_uniform(3), 1'b1);
      idle(8);

      check("sb_drained", sb_q.size(), 0);
      check("res_drained", res_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
